walk_scheduler: RTL and testbench

Round-robin scheduler that shares one LED walker between several request buttons. Raw button inputs are synchronised and edge-detected, then latched as pending requests. One request at a time is granted: the block issues a single start pulse to the walker, then holds the grant until the walker's busy indication has risen and fallen again. It sits between the board buttons and the walker's request/busy pair.

---
 rtl/walk_scheduler.sv | 147 ++++++++++++++
 tb/tb_walk_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/walk_scheduler.sv
// Round-robin scheduler sharing one LED walker between NUM_REQ buttons.
// Optional watchdog on the walker's busy acknowledge: define WALK_SCHED_TIMEOUT_EN.
module walk_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_walker_busy,
    output logic               o_start,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [NUM_REQ-1:0] o_pending,
    output logic               o_timeout
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_param_check
            $error("walk_scheduler: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] sync1_q;
    logic [NUM_REQ-1:0] sync2_q;
    logic [NUM_REQ-1:0] prev_q;
    logic [NUM_REQ-1:0] rise_q;
    logic [NUM_REQ-1:0] pending_q;
    logic [NUM_REQ-1:0] pending_d;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] clr_mask;
    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      owner_q;
    logic [PW-1:0]      ptr_d;
    logic [PW-1:0]      win_idx;
    logic               win_found;
    logic               start_q;
    logic               timeout_q;
`ifdef WALK_SCHED_TIMEOUT_EN
    logic [7:0]         wd_cnt_q;
`endif

    // Scan downward so the lowest offset from the pointer is assigned last and wins.
    always_comb begin
        logic [PW-1:0] idx_w;
        idx_w     = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx_w = PW'((int'(ptr_q) + i) % NUM_REQ);
            if (pending_q[idx_w]) begin
                win_found = 1'b1;
                win_idx   = idx_w;
            end
        end
    end

    always_comb begin
        clr_mask = '0;
        if (state_q == IDLE && win_found) begin
            clr_mask = ONE_HOT0 << win_idx;
        end
        // A fresh edge in the same cycle as the clear keeps the bit set.
        pending_d = (pending_q & ~clr_mask) | rise_q;
        ptr_d     = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            rise_q    <= '0;
            pending_q <= '0;
            grant_q   <= '0;
            ptr_q     <= '0;
            owner_q   <= '0;
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
            state_q   <= IDLE;
`ifdef WALK_SCHED_TIMEOUT_EN
            wd_cnt_q  <= '0;
`endif
        end else begin
            sync1_q   <= i_req;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            rise_q    <= sync2_q & ~prev_q;
            pending_q <= pending_d;
            start_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        grant_q <= clr_mask;
                        owner_q <= win_idx;
                        start_q <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    state_q <= WAIT_BUSY;
`ifdef WALK_SCHED_TIMEOUT_EN
                    wd_cnt_q <= '0;
`endif
                end
                WAIT_BUSY: begin
                    if (i_walker_busy) begin
                        state_q <= RUN;
`ifdef WALK_SCHED_TIMEOUT_EN
                    end else if (wd_cnt_q == 8'(ACK_TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        grant_q   <= '0;
                        ptr_q     <= ptr_d;
                        state_q   <= IDLE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 8'd1;
`endif
                    end
                end
                RUN: begin
                    if (!i_walker_busy) begin
                        grant_q <= '0;
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_start   = start_q;
    assign o_grant   = grant_q;
    assign o_pending = pending_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_walk_scheduler.sv
// Directed bench for walk_scheduler with a simple walker model (busy 5 cycles after start, 4 cycles long).
module tb_walk_scheduler;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [3:0] req       = 4'b0000;
    logic       busy      = 1'b0;
    logic       walker_en = 1'b1;
    logic       start;
    logic [3:0] grant;
    logic [3:0] pending;
    logic       timeout;

    int         n_checks  = 0;
    int         n_pass    = 0;
    int         start_cnt = 0;
    logic [3:0] grant_log[$];

    walk_scheduler #(.NUM_REQ(4), .ACK_TIMEOUT(15)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
        .i_walker_busy (busy),
        .o_start       (start),
        .o_grant       (grant),
        .o_pending     (pending),
        .o_timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s = 0x%0h", tag, got);
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_grant(input string tag, input logic [3:0] mask);
        int n;
        n = 0;
        while (grant !== mask && n < 60) begin
            tick(1);
            n++;
        end
        check_val(tag, {28'd0, grant}, {28'd0, mask});
    endtask

    // exp packs the expected grant order, first grant in the low nibble.
    task automatic check_log(input string tag, input logic [15:0] exp, input int n);
        check_val($sformatf("%s_count", tag), grant_log.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < grant_log.size()) begin
                check_val($sformatf("%s_grant%0d", tag, i), {28'd0, grant_log[i]}, {28'd0, exp[i*4 +: 4]});
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        grant_log.delete();
        start_cnt = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (walker_en && start) begin
                repeat (5) @(negedge clk);
                busy = 1'b1;
                repeat (4) @(negedge clk);
                busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (start) begin
                start_cnt++;
                grant_log.push_back(grant);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        int n;

        // Reset state
        tick(2);
        check_val("rst_start",   {31'd0, start},   32'd0);
        check_val("rst_grant",   {28'd0, grant},   32'd0);
        check_val("rst_pending", {28'd0, pending}, 32'd0);
        check_val("rst_timeout", {31'd0, timeout}, 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Single request, exact latencies relative to sampling edge k
        req = 4'b0100; tick(1); req = 4'b0000;
        tick(2);
        check_val("t1_pend_k2", {28'd0, pending}, 32'h0);
        tick(1);
        check_val("t1_pend_k3", {28'd0, pending}, 32'h4);
        tick(1);
        check_val("t1_start_k4", {31'd0, start},  32'd1);
        check_val("t1_grant_k4", {28'd0, grant},  32'h4);
        check_val("t1_pend_k4",  {28'd0, pending}, 32'h0);
        tick(1);
        check_val("t1_start_k5", {31'd0, start},  32'd0);
        tick(8);
        check_val("t1_grant_k13", {28'd0, grant}, 32'h4);
        tick(1);
        check_val("t1_grant_k14", {28'd0, grant}, 32'h0);
        check_val("t1_starts", start_cnt, 32'd1);
        tick(4);
        // Pointer is now 3: requester 3 beats requester 0
        req = 4'b1001; tick(1); req = 4'b0000;
        tick(50);
        check_log("t1_ptr3", {4'b0000, 4'b0001, 4'b1000, 4'b0100}, 3);

        // Simultaneous requests from pointer 0
        do_reset();
        req = 4'b1011; tick(1); req = 4'b0000;
        tick(60);
        check_log("t2_rr", {4'b0000, 4'b1000, 4'b0010, 4'b0001}, 3);
        check_val("t2_pend_end", {28'd0, pending}, 32'h0);

        // Merge (three presses, one grant) then re-queue during own walk
        req = 4'b0001; tick(1); req = 4'b0000;
        tick(4);
        check_val("t3_grant0", {28'd0, grant}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            req = 4'b0010; tick(1); req = 4'b0000; tick(2);
        end
        check_val("t3_pend_merged", {28'd0, pending}, 32'h2);
        wait_grant("t3_grant1", 4'b0010);
        req = 4'b1010; tick(1); req = 4'b0000;
        tick(60);
        grant_log = grant_log[3:$];
        check_log("t3_requeue", {4'b0010, 4'b1000, 4'b0010, 4'b0001}, 4);

        // Set-wins race: second req0 edge applied on the IDLE->START clear edge
        do_reset();
        req = 4'b0010; tick(1); req = 4'b0000;
        tick(4);
        req = 4'b0001; tick(1); req = 4'b0000;
        tick(6);
        req = 4'b0001; tick(1); req = 4'b0000;
        tick(2);
        check_val("t4_grant_k14", {28'd0, grant},   32'h0);
        check_val("t4_pend_k14",  {28'd0, pending}, 32'h1);
        tick(1);
        check_val("t4_grant_k15", {28'd0, grant},   32'h1);
        check_val("t4_pend_k15",  {28'd0, pending}, 32'h1);
        tick(60);
        check_log("t4_setwins", {4'b0000, 4'b0001, 4'b0001, 4'b0010}, 3);

        // Asynchronous reset in RUN with two requests pending
        do_reset();
        req = 4'b0001; tick(1); req = 4'b0000;
        wait_grant("t5_grant0", 4'b0001);
        req = 4'b1010; tick(1); req = 4'b0000;
        n = 0;
        while (busy !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        check_val("t5_busy_seen", {31'd0, busy}, 32'd1);
        check_val("t5_pend_pre", {28'd0, pending}, 32'hA);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_start",   {31'd0, start},   32'd0);
        check_val("t5_rst_grant",   {28'd0, grant},   32'd0);
        check_val("t5_rst_pending", {28'd0, pending}, 32'd0);
        check_val("t5_rst_timeout", {31'd0, timeout}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        s0 = start_cnt;
        tick(40);
        check_val("t5_no_start", start_cnt, s0);
        req = 4'b0100; tick(1); req = 4'b0000;
        wait_grant("t5_new_grant", 4'b0100);
        tick(30);

`ifdef WALK_SCHED_TIMEOUT_EN
        // Watchdog: walker never answers
        do_reset();
        walker_en = 1'b0;
        req = 4'b0011; tick(1); req = 4'b0000;
        tick(3);
        check_val("t6_pend_k3", {28'd0, pending}, 32'h3);
        tick(1);
        check_val("t6_grant_k4", {28'd0, grant}, 32'h1);
        tick(15);
        check_val("t6_to_k19",    {31'd0, timeout}, 32'd0);
        check_val("t6_grant_k19", {28'd0, grant},   32'h1);
        tick(1);
        check_val("t6_to_k20",    {31'd0, timeout}, 32'd1);
        check_val("t6_grant_k20", {28'd0, grant},   32'h0);
        tick(1);
        check_val("t6_grant_k21", {28'd0, grant},   32'h2);
        check_val("t6_start_k21", {31'd0, start},   32'd1);
        tick(30);
        check_val("t6_to_sticky", {31'd0, timeout}, 32'd1);
        walker_en = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
